placar_truco: RTL and testbench
===============================

// Module: placar_truco
// PURPOSE
//  Match scoreboard directly downstream of the trick/hand distribution stage.
//  Consumes the hand-points word S and hand-winner bit V it emits, then accumulates per-team scores to META.
//  Flags mao de onze / mao de ferro and declares the match winner.
//  Pulses ClrDist back to the distribution stage after each scored hand.
// PARAMETERS
//  PTS_W   4   width of score outputs and of input S
//  META    12  points needed to win the match (must be < 2**PTS_W)
//  CNT_W   6   width of hand counter
// PORTS
//  Clk        in   1      system clock, rising edge
//  Clr_n      in   1      asynchronous active-low reset
//  S          in   PTS_W  hand points from distribution stage; nonzero for one cycle = hand resolved
//  V          in   1      hand winner, valid while S!=0: 1 = team A, 0 = team B
//  ClrPlacar  in   1      synchronous new-match clear, active high
//  PtsA       out  PTS_W  team A score
//  PtsB       out  PTS_W  team B score
//  Maos       out  CNT_W  number of hands scored in this match
//  ClrDist    out  1      one-cycle pulse requesting clear of distribution stage
//  MaoOnze    out  1      exactly one team at META-1
//  MaoFerro   out  1      both teams at META-1
//  Fim        out  1      match over
//  Venc       out  1      match winner (1 = A), valid while Fim=1
// BEHAVIOUR
//  Reset (Clr_n=0, async): all outputs 0; FSM in JOGO.
//  FSM states: JOGO, ONZE, FERRO, FIM. All outputs are registered.
//   - MaoOnze=1 only in ONZE; MaoFerro=1 only in FERRO; Fim=1 only in FIM.
//  Hand event Evt = (S!=0) & state!=FIM, sampled at rising Clk.
//  On Evt, the winner's score takes min(score+S, META):
//   - sum computed PTS_W+1 bits wide, no wrap;
//   - loser's score unchanged;
//   - Maos += 1, saturating at 2**CNT_W-1.
//  Latency: score, Maos and state update on the same edge that samples Evt.
//   - ClrDist=1 during the following cycle only.
//  Next-state evaluation uses the updated scores:
//   - either score == META            -> FIM, Venc = V of that hand;
//   - else both == META-1             -> FERRO;
//   - else exactly one == META-1      -> ONZE;
//   - else                            -> JOGO.
//  FIM is absorbing:
//   - S ignored, scores frozen, no ClrDist pulse;
//   - leaves only via ClrPlacar or Clr_n.
//  ClrPlacar=1: next edge zeroes scores, Maos, Venc and ClrDist; state -> JOGO.
//   - it overrides a simultaneous Evt, which is dropped.
//  S held nonzero for >1 cycle: each cycle counts as a new Evt.
//   - upstream guarantees single-cycle S, so no edge detect here.
//  Reset asserted mid-match or during a ClrDist pulse: immediate return to reset values.
//  S value of 0 never counts as a hand; V is ignored when S=0.
// TESTING
//  T1 reset: Clr_n=0 with random S/V -> all outputs 0; release -> stays 0 with S=0.
//  T2 accumulate: S=1,V=1 then S=3,V=0 then S=6,V=1
//   -> PtsA=7, PtsB=3, Maos=3; each hand gives one ClrDist pulse one cycle later.
//  T3 onze: A=8, then S=3,V=1 -> PtsA=11, MaoOnze=1, state ONZE;
//   then S=3,V=0 with B=0 -> PtsB=3, still ONZE.
//  T4 ferro and win: A=11, B=8, then S=3,V=0 -> MaoFerro=1, MaoOnze=0;
//   then S=1,V=0 -> PtsB=12, Fim=1, Venc=0, MaoFerro=0.
//  T5 saturation/freeze: A=10, then S=12,V=1 -> PtsA=12 (not 22), Fim=1, Venc=1;
//   then S=3,V=0 -> PtsB unchanged, Maos unchanged, no ClrDist.
//  T6 clear priority: ClrPlacar=1 same cycle as S=3,V=1 -> all scores 0, Maos=0, JOGO, no ClrDist;
//   Clr_n pulse mid-ClrDist -> ClrDist drops immediately.

Source files
------------

// File: rtl/placar_truco.sv
// placar_truco: truco match scoreboard
//   Accumulates hand points per team (saturating at META), flags mao de onze /
//   mao de ferro, declares the match winner and pulses ClrDist after each hand.
// Ports:
//   Clk        rising-edge clock
//   Clr_n      asynchronous active-low reset
//   S          hand points; nonzero for one cycle when a hand resolves
//   V          hand winner while S!=0 (1 = team A, 0 = team B)
//   ClrPlacar  synchronous new-match clear
//   PtsA/PtsB  team scores
//   Maos       hands scored this match (saturating)
//   ClrDist    one-cycle pulse after each scored hand
//   MaoOnze    exactly one team at META-1
//   MaoFerro   both teams at META-1
//   Fim        match over
//   Venc       match winner (1 = A), valid while Fim
module placar_truco #(
    parameter int PTS_W = 4,
    parameter int META  = 12,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Clr_n,
    input  logic [PTS_W-1:0] S,
    input  logic             V,
    input  logic             ClrPlacar,
    output logic [PTS_W-1:0] PtsA,
    output logic [PTS_W-1:0] PtsB,
    output logic [CNT_W-1:0] Maos,
    output logic             ClrDist,
    output logic             MaoOnze,
    output logic             MaoFerro,
    output logic             Fim,
    output logic             Venc
);
    typedef enum logic [1:0] {JOGO, ONZE, FERRO, FIM} state_t;

    localparam logic [PTS_W:0]   META_W = (PTS_W+1)'(META);
    localparam logic [PTS_W-1:0] TOP    = PTS_W'(META);
    localparam logic [PTS_W-1:0] QUASE  = PTS_W'(META-1);

    state_t             state_q, state_d;
    logic [PTS_W-1:0]   pts_a_q, pts_a_d, pts_b_q, pts_b_d;
    logic [CNT_W-1:0]   maos_q, maos_d;
    logic               clr_dist_q, clr_dist_d, venc_q, venc_d;
    logic               evt;
    logic [PTS_W:0]     sum_a, sum_b;
    logic [PTS_W-1:0]   sat_a, sat_b, upd_a, upd_b;

    always_comb begin
        evt     = (S != '0) && (state_q != FIM);
        // One extra bit so the sum can exceed META without wrapping before the clamp
        sum_a   = {1'b0, pts_a_q} + {1'b0, S};
        sum_b   = {1'b0, pts_b_q} + {1'b0, S};
        sat_a   = (sum_a > META_W) ? TOP : sum_a[PTS_W-1:0];
        sat_b   = (sum_b > META_W) ? TOP : sum_b[PTS_W-1:0];
        upd_a   = V ? sat_a : pts_a_q;
        upd_b   = V ? pts_b_q : sat_b;
        state_d    = state_q;
        pts_a_d    = pts_a_q;
        pts_b_d    = pts_b_q;
        maos_d     = maos_q;
        venc_d     = venc_q;
        clr_dist_d = 1'b0;
        if (ClrPlacar) begin
            state_d = JOGO;
            pts_a_d = '0;
            pts_b_d = '0;
            maos_d  = '0;
            venc_d  = 1'b0;
        end else if (evt) begin
            pts_a_d    = upd_a;
            pts_b_d    = upd_b;
            maos_d     = (maos_q == '1) ? maos_q : maos_q + CNT_W'(1);
            clr_dist_d = 1'b1;
            // Classification uses the post-hand scores
            if (upd_a == TOP || upd_b == TOP) begin
                state_d = FIM;
                venc_d  = V;
            end else if (upd_a == QUASE && upd_b == QUASE) begin
                state_d = FERRO;
            end else if (upd_a == QUASE || upd_b == QUASE) begin
                state_d = ONZE;
            end else begin
                state_d = JOGO;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q    <= JOGO;
            pts_a_q    <= '0;
            pts_b_q    <= '0;
            maos_q     <= '0;
            clr_dist_q <= 1'b0;
            venc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pts_a_q    <= pts_a_d;
            pts_b_q    <= pts_b_d;
            maos_q     <= maos_d;
            clr_dist_q <= clr_dist_d;
            venc_q     <= venc_d;
        end
    end

    assign PtsA     = pts_a_q;
    assign PtsB     = pts_b_q;
    assign Maos     = maos_q;
    assign ClrDist  = clr_dist_q;
    assign Venc     = venc_q;
    assign MaoOnze  = (state_q == ONZE);
    assign MaoFerro = (state_q == FERRO);
    assign Fim      = (state_q == FIM);
endmodule

// File: tb/tb_placar_truco.sv
// tb_placar_truco: scoreboard-driven self-checking bench for placar_truco
module tb_placar_truco;
    logic       Clk = 1'b0;
    logic       Clr_n = 1'b0;
    logic [3:0] S = '0;
    logic       V = 1'b0;
    logic       ClrPlacar = 1'b0;
    logic [3:0] PtsA, PtsB;
    logic [5:0] Maos;
    logic       ClrDist, MaoOnze, MaoFerro, Fim, Venc;

    placar_truco dut (
        .Clk(Clk), .Clr_n(Clr_n), .S(S), .V(V), .ClrPlacar(ClrPlacar),
        .PtsA(PtsA), .PtsB(PtsB), .Maos(Maos), .ClrDist(ClrDist),
        .MaoOnze(MaoOnze), .MaoFerro(MaoFerro), .Fim(Fim), .Venc(Venc)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int a, b, maos, cd, onze, ferro, fim, venc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int m_a = 0, m_b = 0, m_maos = 0, m_cd = 0, m_fim = 0, m_venc = 0;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_maos = 0; m_cd = 0; m_fim = 0; m_venc = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.a = m_a; e.b = m_b; e.maos = m_maos; e.cd = m_cd;
        e.fim = m_fim; e.venc = m_venc;
        e.ferro = (!m_fim && m_a == 11 && m_b == 11) ? 1 : 0;
        e.onze  = (!m_fim && ((m_a == 11) != (m_b == 11))) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_PtsA"}, int'(PtsA), e.a);
        chk({tag, "_PtsB"}, int'(PtsB), e.b);
        chk({tag, "_Maos"}, int'(Maos), e.maos);
        chk({tag, "_ClrDist"}, int'(ClrDist), e.cd);
        chk({tag, "_MaoOnze"}, int'(MaoOnze), e.onze);
        chk({tag, "_MaoFerro"}, int'(MaoFerro), e.ferro);
        chk({tag, "_Fim"}, int'(Fim), e.fim);
        chk({tag, "_Venc"}, int'(Venc), e.venc);
    endtask

    task automatic step(input string tag, input int s, input int v, input int clr);
        if (clr != 0) begin
            m_a = 0; m_b = 0; m_maos = 0; m_cd = 0; m_fim = 0; m_venc = 0;
        end else if (s != 0 && m_fim == 0) begin
            if (v != 0) m_a = (m_a + s > 12) ? 12 : m_a + s;
            else        m_b = (m_b + s > 12) ? 12 : m_b + s;
            m_maos = (m_maos == 63) ? 63 : m_maos + 1;
            m_cd = 1;
            if (m_a == 12 || m_b == 12) begin
                m_fim = 1;
                m_venc = v;
            end
        end else begin
            m_cd = 0;
        end
        push_exp();
        S = 4'(s); V = (v != 0); ClrPlacar = (clr != 0);
        @(posedge Clk);
        #1;
        S = '0; V = 1'b0; ClrPlacar = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        // T1 reset with garbage inputs
        for (int i = 0; i < 3; i++) begin
            S = 4'($urandom_range(1, 15));
            V = 1'($urandom);
            model_reset();
            push_exp();
            @(posedge Clk);
            #1;
            pop_check("reset");
        end
        S = '0; V = 1'b0;
        Clr_n = 1'b1;
        step("idle", 0, 0, 0);
        step("v_no_s", 0, 1, 0);
        // T2 accumulate
        step("acc1", 1, 1, 0);
        step("acc1_gap", 0, 0, 0);
        step("acc2", 3, 0, 0);
        step("acc2_gap", 0, 0, 0);
        step("acc3", 6, 1, 0);
        step("acc3_gap", 0, 0, 0);
        // T3 onze
        step("clr1", 0, 0, 1);
        step("a8", 8, 1, 0);
        step("onze_a", 3, 1, 0);
        step("onze_b3", 3, 0, 0);
        step("hold_s1", 5, 0, 0);
        // T4 ferro and win (B was 8 now)
        step("ferro", 3, 0, 0);
        step("ferro_gap", 0, 0, 0);
        step("win_b", 1, 0, 0);
        step("fim_hold", 0, 0, 0);
        // T5 saturation and freeze
        step("clr2", 0, 0, 1);
        step("a10", 10, 1, 0);
        step("sat_a", 12, 1, 0);
        step("frozen", 3, 0, 0);
        step("frozen2", 15, 1, 0);
        // back-to-back hands (S held two cycles)
        step("clr3", 0, 0, 1);
        step("b2b1", 2, 0, 0);
        step("b2b2", 2, 0, 0);
        // T6 clear beats simultaneous hand
        step("clr_evt", 3, 1, 1);
        step("clr_evt_gap", 0, 0, 0);
        step("pre_rst", 3, 1, 0);
        // async reset while ClrDist is high
        #2;
        Clr_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        pop_check("async_rst");
        @(posedge Clk);
        #1;
        Clr_n = 1'b1;
        step("post_rst", 4, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
